// File: rtl/serial_add_seq_if.sv
// Operand/result handshake bundle for the bit-serial adder.
// The producer/consumer side drives through master; the adder uses slave.
interface serial_add_seq_if #(
  parameter int unsigned WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum_out;
  logic             carry_out;
  logic             busy;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, sum_out, carry_out, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, sum_out, carry_out, busy
  );
endinterface

// File: rtl/serial_add_seq.sv
// Bit-serial adder: accepts an operand pair, runs WIDTH LSB-first full-adder
// steps through a carry flop, then presents {carry, sum} until taken.
module serial_add_seq #(
  parameter int unsigned WIDTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  serial_add_seq_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic step_sum;
  logic step_carry;

  assign step_sum   = a_q[0] ^ b_q[0] ^ carry_q;
  assign step_carry = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

  // The result is copied into separate output flops on the last step so it
  // survives the next operation's carry clear and shifting until its DONE.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d        = bus.in_a;
          b_d        = bus.in_b;
          carry_d    = 1'b0;
          cnt_d      = '0;
          state_d    = SHIFT;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      SHIFT: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = {step_sum, res_q[WIDTH-1:1]};
        carry_d = step_carry;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d     = DONE;
          sum_d       = {step_sum, res_q[WIDTH-1:1]};
          cout_d      = step_carry;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum_out   = sum_q;
  assign bus.carry_out = cout_q;
  assign bus.busy      = busy_q;

endmodule
